// File: rtl/spi_flash_target.sv
// spi_flash_target
//   Serial NOR flash read-port responder. Lets an on-chip SPI flash master
//   (e.g. an XIP mapper) boot from FPGA-internal memory. SCK, CS_N and the
//   IO pads are oversampled in the clk domain. Two commands are decoded:
//   0x03 (single read) and 0xBB (dual-I/O read). Data bytes come from a
//   byte-wide synchronous memory port and are shifted out MSB first.
//
// Ports
//   clk, reset          system clock, async active-high reset
//   sck, cs_n           SPI mode-0 clock and active-low select (async)
//   io0_in, io1_in      IO pad inputs (io0 = MOSI in single mode)
//   io0_out/io0_oe      IO0 drive value / enable
//   io1_out/io1_oe      IO1 drive value / enable (io1 = MISO in single mode)
//   mem_addr            byte address to backing memory
//   mem_rstrb           one-cycle read strobe
//   mem_rdata           read data, valid one clk after mem_rstrb
//   active              high while a transaction is being decoded
module spi_flash_target #(
  parameter int unsigned ADDR_WIDTH  = 24,
  parameter int unsigned MODE_CLOCKS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sck,
  input  logic                  cs_n,
  input  logic                  io0_in,
  input  logic                  io1_in,
  output logic                  io0_out,
  output logic                  io0_oe,
  output logic                  io1_out,
  output logic                  io1_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rstrb,
  input  logic [7:0]            mem_rdata,
  output logic                  active
);

  localparam logic [7:0] MODE_LAST = 8'(MODE_CLOCKS - 1);

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR_S,
    ADDR_D,
    MODE_D,
    DATA_S,
    DATA_D,
    IGNORE
  } state_t;

  state_t      state;

  logic [1:0]  sck_sync;
  logic [1:0]  cs_sync;
  logic [1:0]  io0_sync;
  logic [1:0]  io1_sync;
  logic        sck_d;

  logic        sck_s;
  logic        cs_s;
  logic        io0_s;
  logic        io1_s;
  logic        sck_rise;
  logic        sck_fall;

  logic [7:0]  bit_cnt;
  logic [22:0] in_sh;       // command / address shifter
  logic [23:0] sh_single;   // in_sh with one io0 bit appended
  logic [23:0] sh_dual;     // in_sh with an {io1,io0} pair appended
  logic [7:0]  shreg;       // outgoing data byte
  logic [7:0]  pf_buf;      // prefetched next byte
  logic        first_load;  // next read return goes straight to shreg
  logic        fetch_next;  // issue the prefetch strobe this clk
  logic        rd_valid;    // mem_rdata is valid this clk

  assign sck_s     = sck_sync[1];
  assign cs_s      = cs_sync[1];
  assign io0_s     = io0_sync[1];
  assign io1_s     = io1_sync[1];
  assign sck_rise  = sck_s & ~sck_d;
  assign sck_fall  = ~sck_s & sck_d;
  assign sh_single = {in_sh, io0_s};
  assign sh_dual   = {in_sh[21:0], io1_s, io0_s};

  // cs_n synchroniser resets to the deselected level so that leaving reset
  // with the bus idle does not look like a select.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync <= '0;
      cs_sync  <= '1;
      io0_sync <= '0;
      io1_sync <= '0;
      sck_d    <= 1'b0;
    end else begin
      sck_sync <= {sck_sync[0], sck};
      cs_sync  <= {cs_sync[0], cs_n};
      io0_sync <= {io0_sync[0], io0_in};
      io1_sync <= {io1_sync[0], io1_in};
      sck_d    <= sck_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      io0_out    <= 1'b0;
      io0_oe     <= 1'b0;
      io1_out    <= 1'b0;
      io1_oe     <= 1'b0;
      mem_addr   <= '0;
      mem_rstrb  <= 1'b0;
      active     <= 1'b0;
      bit_cnt    <= '0;
      in_sh      <= '0;
      shreg      <= '0;
      pf_buf     <= '0;
      first_load <= 1'b0;
      fetch_next <= 1'b0;
      rd_valid   <= 1'b0;
    end else begin
      mem_rstrb <= 1'b0;
      rd_valid  <= mem_rstrb;

      // Deselect wins over any SCK event seen in the same clk.
      if (cs_s) begin
        state      <= IDLE;
        io0_out    <= 1'b0;
        io0_oe     <= 1'b0;
        io1_out    <= 1'b0;
        io1_oe     <= 1'b0;
        active     <= 1'b0;
        first_load <= 1'b0;
        fetch_next <= 1'b0;
      end else begin
        // Read pipeline: the initial return fills shreg, later returns fill
        // the prefetch buffer. Each shreg load schedules the next fetch.
        if (state == DATA_S || state == DATA_D) begin
          if (rd_valid) begin
            if (first_load) begin
              shreg      <= mem_rdata;
              first_load <= 1'b0;
              fetch_next <= 1'b1;
            end else begin
              pf_buf <= mem_rdata;
            end
          end
          if (fetch_next) begin
            mem_rstrb  <= 1'b1;
            mem_addr   <= mem_addr + 1'b1;
            fetch_next <= 1'b0;
          end
        end

        case (state)
          IDLE: begin
            state   <= CMD;
            active  <= 1'b1;
            bit_cnt <= '0;
            in_sh   <= '0;
          end

          CMD: begin
            if (sck_rise) begin
              if (bit_cnt == 8'd7) begin
                bit_cnt <= '0;
                in_sh   <= '0;
                case (sh_single[7:0])
                  8'h03:   state <= ADDR_S;
                  8'hBB:   state <= ADDR_D;
                  default: state <= IGNORE;
                endcase
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
                in_sh   <= sh_single[22:0];
              end
            end
          end

          ADDR_S: begin
            if (sck_rise) begin
              in_sh <= sh_single[22:0];
              if (bit_cnt == 8'd23) begin
                bit_cnt    <= '0;
                state      <= DATA_S;
                io1_oe     <= 1'b1;
                io0_oe     <= 1'b0;
                mem_addr   <= ADDR_WIDTH'(sh_single);
                mem_rstrb  <= 1'b1;
                first_load <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
              end
            end
          end

          ADDR_D: begin
            if (sck_rise) begin
              in_sh <= sh_dual[22:0];
              if (bit_cnt == 8'd11) begin
                bit_cnt  <= '0;
                // Address is parked in mem_addr so MODE_D needs no copy of it.
                mem_addr <= ADDR_WIDTH'(sh_dual);
                if (MODE_CLOCKS == 0) begin
                  state      <= DATA_D;
                  io0_oe     <= 1'b1;
                  io1_oe     <= 1'b1;
                  mem_rstrb  <= 1'b1;
                  first_load <= 1'b1;
                end else begin
                  state <= MODE_D;
                end
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
              end
            end
          end

          MODE_D: begin
            if (sck_rise) begin
              if (bit_cnt == MODE_LAST) begin
                bit_cnt    <= '0;
                state      <= DATA_D;
                io0_oe     <= 1'b1;
                io1_oe     <= 1'b1;
                mem_rstrb  <= 1'b1;
                first_load <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
              end
            end
          end

          DATA_S: begin
            if (sck_fall) begin
              io1_out <= shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
            end else if (sck_rise) begin
              if (bit_cnt == 8'd7) begin
                bit_cnt    <= '0;
                shreg      <= pf_buf;
                fetch_next <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
              end
            end
          end

          DATA_D: begin
            if (sck_fall) begin
              io1_out <= shreg[7];
              io0_out <= shreg[6];
              shreg   <= {shreg[5:0], 2'b00};
            end else if (sck_rise) begin
              if (bit_cnt == 8'd3) begin
                bit_cnt    <= '0;
                shreg      <= pf_buf;
                fetch_next <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 8'd1;
              end
            end
          end

          IGNORE: begin
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_flash_target.sv
// tb_spi_flash_target
//   Directed bench for spi_flash_target: acts as an SPI mode-0 master and
//   as the byte-wide synchronous memory behind the responder.
module tb_spi_flash_target;

  localparam int HALF = 50;

  logic        clk;
  logic        reset;
  logic        sck;
  logic        cs_n;
  logic        io0_in;
  logic        io1_in;
  logic        io0_out;
  logic        io0_oe;
  logic        io1_out;
  logic        io1_oe;
  logic [23:0] mem_addr;
  logic        mem_rstrb;
  logic [7:0]  mem_rdata;
  logic        active;

  int n_cmp = 0;
  int n_err = 0;

  logic [7:0] mem [int unsigned];
  int unsigned strobes [$];

  spi_flash_target #(
    .ADDR_WIDTH  (24),
    .MODE_CLOCKS (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sck       (sck),
    .cs_n      (cs_n),
    .io0_in    (io0_in),
    .io1_in    (io1_in),
    .io0_out   (io0_out),
    .io0_oe    (io0_oe),
    .io1_out   (io1_out),
    .io1_oe    (io1_oe),
    .mem_addr  (mem_addr),
    .mem_rstrb (mem_rstrb),
    .mem_rdata (mem_rdata),
    .active    (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_read(input logic [23:0] a);
    int unsigned k;
    k = int'(a);
    if (mem.exists(k)) return mem[k];
    return 8'h00;
  endfunction

  always @(posedge clk) begin
    if (mem_rstrb) begin
      mem_rdata <= mem_read(mem_addr);
      strobes.push_back(int'(mem_addr));
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sck_cycle(input logic d0, input logic d1, output logic r0, output logic r1);
    io0_in = d0;
    io1_in = d1;
    #HALF;
    sck = 1'b1;
    r0 = io0_out;
    r1 = io1_out;
    #HALF;
    sck = 1'b0;
  endtask

  task automatic send_single(input logic [23:0] v, input int nbits);
    logic r0, r1;
    for (int i = nbits - 1; i >= 0; i--) sck_cycle(v[i], 1'b0, r0, r1);
  endtask

  task automatic send_dual(input logic [23:0] v, input int npairs);
    logic r0, r1;
    for (int i = npairs - 1; i >= 0; i--) sck_cycle(v[2*i], v[2*i+1], r0, r1);
  endtask

  task automatic read_single(output logic [7:0] b);
    logic r0, r1;
    b = '0;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(1'b0, 1'b0, r0, r1);
      b = {b[6:0], r1};
    end
  endtask

  task automatic read_dual(output logic [7:0] b, output logic [1:0] first);
    logic r0, r1;
    b = '0;
    first = '0;
    for (int i = 0; i < 4; i++) begin
      sck_cycle(1'b0, 1'b0, r0, r1);
      if (i == 0) first = {r1, r0};
      b = {b[5:0], r1, r0};
    end
  endtask

  initial begin
    logic [7:0] b;
    logic [1:0] pr;
    logic       r0, r1;
    logic       any_oe;
    int         n_strb;

    mem[32'h10]     = 8'hA5;
    mem[32'h11]     = 8'h3C;
    mem[32'h840000] = 8'h78;
    mem[32'h840001] = 8'h56;
    mem[32'h840002] = 8'h34;
    mem[32'h840003] = 8'h12;
    mem[32'hFFFFFF] = 8'hC3;
    mem[32'h0]      = 8'h5A;

    reset = 1'b1; sck = 1'b0; cs_n = 1'b1; io0_in = 1'b0; io1_in = 1'b0;
    mem_rdata = 8'h00;
    #20;
    check("rst_io0_out", io0_out, 0);
    check("rst_io0_oe", io0_oe, 0);
    check("rst_io1_out", io1_out, 0);
    check("rst_io1_oe", io1_oe, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rstrb", mem_rstrb, 0);
    check("rst_active", active, 0);
    reset = 1'b0;
    #40;

    // Single read at 0x000010
    strobes.delete();
    cs_n = 1'b0;
    #40;
    check("sr_active", active, 1);
    send_single(24'h03, 8);
    send_single(24'h000010, 24);
    read_single(b);
    check("sr_byte0", b, 8'hA5);
    check("sr_io0_oe", io0_oe, 0);
    check("sr_io1_oe", io1_oe, 1);
    read_single(b);
    check("sr_byte1", b, 8'h3C);
    cs_n = 1'b1;
    #40;
    check("sr_nstrobe_ge3", strobes.size() >= 3, 1);
    check("sr_strobe0", strobes[0], 32'h10);
    check("sr_strobe1", strobes[1], 32'h11);
    check("sr_strobe2", strobes[2], 32'h12);
    check("sr_end_active", active, 0);
    check("sr_end_io1_oe", io1_oe, 0);

    // Dual read at 0x840000, then reset while in DATA_D
    strobes.delete();
    cs_n = 1'b0;
    #40;
    send_single(24'hBB, 8);
    send_dual(24'h840000, 12);
    send_dual(24'h0, 4);
    read_dual(b, pr);
    check("dr_first_pair", pr, 2'b01);
    check("dr_byte0", b, 8'h78);
    check("dr_io0_oe", io0_oe, 1);
    check("dr_io1_oe", io1_oe, 1);
    read_dual(b, pr);
    check("dr_byte1", b, 8'h56);
    check("dr_strobe0", strobes[0], 32'h840000);
    #10;
    reset = 1'b1;
    #1;
    check("mr_io0_out", io0_out, 0);
    check("mr_io0_oe", io0_oe, 0);
    check("mr_io1_out", io1_out, 0);
    check("mr_io1_oe", io1_oe, 0);
    check("mr_mem_addr", mem_addr, 0);
    check("mr_rstrb", mem_rstrb, 0);
    check("mr_active", active, 0);
    #9;
    cs_n = 1'b1;
    #30;
    reset = 1'b0;
    #30;
    cs_n = 1'b0;
    #40;
    send_single(24'h03, 8);
    send_single(24'h000000, 24);
    read_single(b);
    check("mr_post_byte", b, 8'h5A);
    cs_n = 1'b1;
    #40;

    // Address wrap
    strobes.delete();
    cs_n = 1'b0;
    #40;
    send_single(24'h03, 8);
    send_single(24'hFFFFFF, 24);
    read_single(b);
    check("wr_byte0", b, 8'hC3);
    read_single(b);
    check("wr_byte1", b, 8'h5A);
    check("wr_strobe0", strobes[0], 32'hFFFFFF);
    check("wr_strobe1", strobes[1], 32'h0);
    cs_n = 1'b1;
    #40;

    // Unknown command 0x9F
    strobes.delete();
    cs_n = 1'b0;
    #40;
    send_single(24'h9F, 8);
    any_oe = 1'b0;
    for (int i = 0; i < 32; i++) begin
      sck_cycle(1'b0, 1'b0, r0, r1);
      any_oe = any_oe | io0_oe | io1_oe;
    end
    check("uk_any_oe", any_oe, 0);
    check("uk_nstrobe", strobes.size(), 0);
    check("uk_active", active, 1);
    cs_n = 1'b1;
    #40;
    check("uk_end_active", active, 0);

    // cs_n abort after 3 data bits, then an immediate new read
    strobes.delete();
    cs_n = 1'b0;
    #40;
    send_single(24'h03, 8);
    send_single(24'h000010, 24);
    b = '0;
    for (int i = 0; i < 3; i++) begin
      sck_cycle(1'b0, 1'b0, r0, r1);
      b = {b[6:0], r1};
    end
    check("ab_bits", b, 8'h05);
    cs_n = 1'b1;
    #30;
    check("ab_io0_oe", io0_oe, 0);
    check("ab_io1_oe", io1_oe, 0);
    check("ab_active", active, 0);
    n_strb = strobes.size();
    check("ab_nstrobe", n_strb, 2);
    #40;
    check("ab_no_more_strobe", strobes.size(), n_strb);
    cs_n = 1'b0;
    #40;
    send_single(24'h03, 8);
    send_single(24'h000011, 24);
    read_single(b);
    check("ab_restart_byte", b, 8'h3C);
    cs_n = 1'b1;
    #40;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/spi_flash_target.md
Name: spi_flash_target

Overview:
SPI flash responder that emulates a serial NOR flash read port so that an on-chip SPI flash master, such as the XIP flash mapper, can be exercised and booted from FPGA-internal memory without a physical flash.
- Oversamples SCK, CS_N and the IO lines in the system clock domain.
- Decodes single read (0x03) and dual-I/O read (0xBB).
- Fetches bytes from a byte-wide synchronous memory port and shifts them out MSB first.

Parameters:
ADDR_WIDTH, 24, flash byte-address width; the address counter wraps modulo 2^ADDR_WIDTH.
MODE_CLOCKS, 4, SCK clocks of mode/dummy bits after the address in 0xBB; values sampled in these clocks are ignored.

Ports:
clk  input  1  system clock; SCK must satisfy f_sck <= f_clk/8.
reset  input  1  asynchronous, active-high reset.
sck  input  1  SPI clock from the master, SPI mode 0; asynchronous to clk.
cs_n  input  1  chip select, active low; asynchronous.
io0_in  input  1  IO0 pad input (MOSI in single mode).
io1_in  input  1  IO1 pad input.
io0_out  output  1  IO0 drive value.
io0_oe  output  1  IO0 output enable.
io1_out  output  1  IO1 drive value (MISO in single mode).
io1_oe  output  1  IO1 output enable.
mem_addr  output  ADDR_WIDTH  byte address to the backing memory.
mem_rstrb  output  1  one-cycle read strobe.
mem_rdata  input  8  read data, valid exactly 1 clk after mem_rstrb.
active  output  1  high while a transaction is decoded (state != IDLE).

Behaviour:
- Reset: the clock is clk; reset is asynchronous and active-high. All outputs are 0, state is IDLE, and the address counter and shift registers are cleared.
- Synchronisation:
  - sck, cs_n, io0_in and io1_in each pass through a 2-FF synchroniser.
  - SCK rise/fall events are detected from the synchronised sck versus its previous value.
  - The total input-to-event latency is 3 clk.
- Sampling and driving: inputs are sampled on the rise event; outputs change only on the fall event. Bits are MSB first.
- Synchronised cs_n high in any state:
  - next state is IDLE, io*_oe=0, active=0;
  - any partial command or address is discarded.
- States:
  - IDLE: waits for the synchronised cs_n fall, which clears the bit counter and enters CMD.
  - CMD: 8 rise events sample io0.
    - Byte 0x03 enters ADDR_S.
    - Byte 0xBB enters ADDR_D.
    - Any other byte enters IGNORE.
  - ADDR_S: 24 rises on io0 build the address (upper bits truncated to ADDR_WIDTH). The last rise enters DATA_S.
  - ADDR_D: 12 rises, each shifting in {io1,io0} (io1 is the more significant bit). After 12 rises, enters MODE_D.
  - MODE_D: MODE_CLOCKS rises; bits are ignored. After the last rise, enters DATA_D. With MODE_CLOCKS=0, ADDR_D goes directly to DATA_D.
  - DATA_S:
    - io1_oe=1, io0_oe=0.
    - Each fall event drives the next bit on io1_out: bit7 first, then bit6 down to bit0.
    - After bit0 is consumed (8 rises), the next byte follows with no gap.
  - DATA_D:
    - io0_oe=io1_oe=1.
    - Each fall drives the pair {io1,io0} = {b7,b6}, then {b5,b4}, {b3,b2}, {b1,b0}.
    - 4 rises consume a byte.
  - IGNORE: outputs remain tri-stated (oe=0) until cs_n rises.
- Fetch and prefetch:
  - On the final address rise (or final MODE rise for 0xBB), mem_rstrb pulses with mem_addr set to the received address.
  - mem_rdata is loaded into the shift register on the following clk.
  - The next mem_rstrb, at address+1, is issued one clk after each shift-register load. The fetched byte is held in a prefetch buffer and transferred to the shift register when the current byte is consumed.
  - The first bit must be driven at the fall event that follows the last address/mode rise.
- Address increment:
  - The address increments by 1 per byte fetched.
  - At 2^ADDR_WIDTH-1 it wraps to 0.
- mem_rstrb is never asserted in IDLE, CMD, ADDR_*, MODE_D or IGNORE, except for the initial fetch described above.
- cs_n rising mid-byte: the remaining bits are dropped and there is no further mem_rstrb. A new transaction restarts cleanly from CMD.
- Simultaneous cs_n rise and sck event in the same clk: the cs_n rise has priority.

Test Plan:
- Reset mid-transaction: assert reset during DATA_D -> all outputs 0 immediately; after release and a new 0x03 at address 0, the bench reads the correct byte.
- Single read:
  - Memory holds 0x10:A5, 0x11:3C.
  - Master sends 0x03, 000010, then 16 SCK clocks.
  - Required: io1 returns 0xA5 then 0x3C, io0_oe=0, mem_rstrb addresses 0x10, 0x11, 0x12.
- Dual read:
  - Memory holds 0x840000:0x12345678 (little-endian bytes).
  - Master sends 0xBB, 840000 dual, 4 mode clocks, then 8 clocks.
  - Required: bytes 0x78, 0x56 appear, with pairs 01, 11, 10, 00 first.
- Wrap: 0x03 at FFFFFF, read 2 bytes -> mem[FFFFFF] then mem[000000].
- Unknown command 0x9F followed by 32 SCK clocks -> io0_oe=io1_oe=0 throughout, no mem_rstrb, active=1 until cs_n rises.
- cs_n abort:
  - cs_n rises after 3 data bits -> oe=0 and active=0 within 3 clk, no further strobes.
  - An immediate new 0x03 transaction decodes correctly.
